// File: rtl/ray_batch_streamer_if.sv
// ray_batch_streamer_if: ray FIFO, triangle SRAM and instruction bus of the batch streamer
// master: streamer side (pops rays, drives SRAM address, writes instructions, busy)
// slave: environment side (FIFO status/data, tri_count, SRAM data, downstream full)
interface ray_batch_streamer_if #(
  parameter int D_BITS = 32,
  parameter int M_BITS = 12,
  parameter int LANES  = 4
) ();
  logic                       in_empty;
  logic [6*D_BITS-1:0]        ray_in;
  logic                       in_rd_en;
  logic [M_BITS-1:0]          tri_count;
  logic [M_BITS-1:0]          mem_addr;
  logic [12*D_BITS-1:0]       mem_data;
  logic                       out_full;
  logic                       out_wr_en;
  logic [LANES*6*D_BITS-1:0]  out_rays;
  logic [LANES-1:0]           out_mask;
  logic [12*D_BITS-1:0]       out_tri;
  logic [M_BITS-1:0]          out_tri_idx;
  logic                       out_last;
  logic                       busy;
  modport master (
    input  in_empty, ray_in, tri_count, mem_data, out_full,
    output in_rd_en, mem_addr, out_wr_en, out_rays, out_mask, out_tri, out_tri_idx, out_last, busy
  );
  modport slave (
    output in_empty, ray_in, tri_count, mem_data, out_full,
    input  in_rd_en, mem_addr, out_wr_en, out_rays, out_mask, out_tri, out_tri_idx, out_last, busy
  );
endinterface

// File: rtl/ray_batch_streamer.sv
// ray_batch_streamer: batches up to LANES rays and streams every triangle once per batch
// clock/reset: rising-edge clock, async active-low reset
// bus (master): ray FIFO pop, triangle SRAM read port, instruction output, busy
module ray_batch_streamer #(
  parameter int D_BITS = 32,
  parameter int M_BITS = 12,
  parameter int LANES  = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  ray_batch_streamer_if.master bus
);
  localparam int RW = 6 * D_BITS;
  localparam int LW = $clog2(LANES + 1);
  typedef enum logic [2:0] {IDLE, LOAD, FETCH, WAIT, EMIT} state_t;
  state_t               state_q, state_d;
  logic [LW-1:0]        lane_cnt_q, lane_cnt_d, lane_sel, lane_nxt;
  logic [LANES*RW-1:0]  rays_q, rays_d;
  logic [LANES-1:0]     mask_q, mask_d;
  logic [M_BITS-1:0]    tri_cnt_q, tri_cnt_d, tri_idx_q, tri_idx_d;
  logic [M_BITS-1:0]    mem_addr_q, mem_addr_d, out_idx_q, out_idx_d;
  logic [12*D_BITS-1:0] out_tri_q, out_tri_d;
  logic                 pop, close, last, wr;
  always_comb begin
    state_d    = state_q;
    lane_cnt_d = lane_cnt_q;
    rays_d     = rays_q;
    mask_d     = mask_q;
    tri_cnt_d  = tri_cnt_q;
    tri_idx_d  = tri_idx_q;
    out_tri_d  = out_tri_q;
    out_idx_d  = out_idx_q;
    pop        = (state_q == IDLE || state_q == LOAD) && !bus.in_empty;
    lane_sel   = state_q == IDLE ? '0 : lane_cnt_q;
    lane_nxt   = lane_sel + LW'(1);
    last       = state_q == EMIT && tri_idx_q == tri_cnt_q - M_BITS'(1);
    wr         = state_q == EMIT && !bus.out_full;
    // a batch closes on the pop that fills the last lane, or on an empty FIFO while loading
    close      = (pop && lane_nxt == LW'(LANES)) || (state_q == LOAD && bus.in_empty);
    if (pop) begin
      for (int j = 0; j < LANES; j++)
        if (lane_sel == LW'(j)) begin
          rays_d[j*RW +: RW] = bus.ray_in;
          mask_d[j]          = 1'b1;
        end
      lane_cnt_d = lane_nxt;
      state_d    = LOAD;
    end
    if (close) begin
      tri_cnt_d = bus.tri_count;
      tri_idx_d = '0;
      state_d   = bus.tri_count == '0 ? IDLE : FETCH;
      mask_d    = bus.tri_count == '0 ? '0 : mask_d;
    end
    if (state_q == FETCH) state_d = WAIT;
    if (state_q == WAIT) begin
      out_tri_d = bus.mem_data;
      out_idx_d = tri_idx_q;
      state_d   = EMIT;
    end
    if (wr) begin
      state_d   = last ? IDLE : FETCH;
      tri_idx_d = last ? tri_idx_q : tri_idx_q + M_BITS'(1);
      mask_d    = last ? '0 : mask_q;
    end
  end
  // the address is registered on entry to FETCH so the SRAM sees it during FETCH
  assign mem_addr_d = state_d == FETCH ? tri_idx_d : mem_addr_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      lane_cnt_q <= '0;
      rays_q     <= '0;
      mask_q     <= '0;
      tri_cnt_q  <= '0;
      tri_idx_q  <= '0;
      mem_addr_q <= '0;
      out_idx_q  <= '0;
      out_tri_q  <= '0;
    end else begin
      state_q    <= state_d;
      lane_cnt_q <= lane_cnt_d;
      rays_q     <= rays_d;
      mask_q     <= mask_d;
      tri_cnt_q  <= tri_cnt_d;
      tri_idx_q  <= tri_idx_d;
      mem_addr_q <= mem_addr_d;
      out_idx_q  <= out_idx_d;
      out_tri_q  <= out_tri_d;
    end
  end
  // the pop strobe is gated by reset so no ray is consumed while reset is held
  assign bus.in_rd_en    = pop && reset;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.out_wr_en   = wr;
  assign bus.out_rays    = rays_q;
  assign bus.out_mask    = mask_q;
  assign bus.out_tri     = out_tri_q;
  assign bus.out_tri_idx = out_idx_q;
  assign bus.out_last    = last;
  assign bus.busy        = state_q != IDLE;
endmodule

// File: tb/tb_ray_batch_streamer.sv
// tb_ray_batch_streamer: scoreboard bench for the 4-lane and 1-lane streamer configurations
module tb_ray_batch_streamer;
  typedef struct {
    int           cyc;
    logic [767:0] rays;
    logic [3:0]   mask;
    logic [383:0] trd;
    logic [11:0]  idx;
    logic         last;
  } exp_t;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;
  ray_batch_streamer_if #(.D_BITS(32), .M_BITS(12), .LANES(4)) b4 ();
  ray_batch_streamer_if #(.D_BITS(32), .M_BITS(4), .LANES(1)) b1 ();
  ray_batch_streamer #(.D_BITS(32), .M_BITS(12), .LANES(4)) u4 (.clock(clock), .reset(reset), .bus(b4.master));
  ray_batch_streamer #(.D_BITS(32), .M_BITS(4), .LANES(1)) u1 (.clock(clock), .reset(reset), .bus(b1.master));
  int cyc = 0, base = 0, total = 0, bad = 0, nid = 1, pops1 = 0;
  exp_t q4[$], q1[$];
  exp_t a4, a1;
  logic [191:0] fq[$];
  logic rd1;
  function automatic logic [383:0] tri_word(input int a);
    logic [383:0] w;
    for (int k = 0; k < 12; k++) w[32*k +: 32] = 32'h7E00_0000 ^ 32'(a * 256 + k);
    return w;
  endfunction
  function automatic logic [191:0] ray_word(input int r);
    logic [191:0] w;
    for (int s = 0; s < 6; s++) w[32*s +: 32] = 32'hA500_0000 + 32'(r * 16 + s);
    return w;
  endfunction
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) begin
    b4.mem_data <= tri_word(int'(b4.mem_addr));
    b1.mem_data <= tri_word(int'(b1.mem_addr));
  end
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, got, want);
    end
  endtask
  task automatic cmp(input string n, input exp_t a, input exp_t e);
    bit rays_ok = 1'b1;
    for (int j = 0; j < 4; j++)
      if (e.mask[j] && a.rays[192*j +: 192] !== e.rays[192*j +: 192]) rays_ok = 1'b0;
    total++;
    if (!(a.cyc == e.cyc && a.mask === e.mask && a.trd === e.trd && a.idx === e.idx && a.last === e.last && rays_ok)) begin
      bad++;
      $display("FAIL %s_write: got cyc=%0d idx=%0d mask=%h last=%b tri_ok=%b rays_ok=%b want cyc=%0d idx=%0d mask=%h last=%b",
               n, a.cyc, a.idx, a.mask, a.last, a.trd === e.trd, rays_ok, e.cyc, e.idx, e.mask, e.last);
    end
  endtask
  always @(negedge clock)
    if (b4.out_wr_en === 1'b1) begin
      a4.cyc  = cyc - base;
      a4.rays = 768'(b4.out_rays);
      a4.mask = b4.out_mask;
      a4.trd  = b4.out_tri;
      a4.idx  = b4.out_tri_idx;
      a4.last = b4.out_last;
      if (q4.size() == 0) begin
        total++;
        bad++;
        $display("FAIL u4_unexpected_write: got idx=%0d at cyc=%0d want no write", a4.idx, a4.cyc);
      end else cmp("u4", a4, q4.pop_front());
    end
  always @(negedge clock)
    if (b1.out_wr_en === 1'b1) begin
      a1.cyc  = cyc - base;
      a1.rays = 768'(b1.out_rays);
      a1.mask = 4'(b1.out_mask);
      a1.trd  = b1.out_tri;
      a1.idx  = 12'(b1.out_tri_idx);
      a1.last = b1.out_last;
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL u1_unexpected_write: got idx=%0d at cyc=%0d want no write", a1.idx, a1.cyc);
      end else cmp("u1", a1, q1.pop_front());
    end
  task automatic push_exp(input bit one, input int c0, input int n, input logic [3:0] m,
                          input int r0, input int r1, input int r2, input int r3);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.cyc  = c0 + 3 * i;
      e.idx  = 12'(i);
      e.last = i == n - 1;
      e.mask = m;
      e.trd  = tri_word(i);
      e.rays = {ray_word(r3), ray_word(r2), ray_word(r1), ray_word(r0)};
      if (one) q1.push_back(e);
      else q4.push_back(e);
    end
  endtask
  task automatic push_rays(input int k);
    for (int i = 0; i < k; i++) fq.push_back(ray_word(nid++));
  endtask
  task automatic step(output logic rd);
    @(negedge clock);
    rd  = b4.in_rd_en;
    rd1 = b1.in_rd_en;
    @(posedge clock);
    #1;
    if (rd) void'(fq.pop_front());
    if (rd1) begin
      pops1++;
      b1.in_empty = 1'b1;
    end
    b4.in_empty = fq.size() == 0;
    if (fq.size() != 0) b4.ray_in = fq[0];
  endtask
  task automatic start();
    logic rd;
    step(rd);
    base = cyc;
  endtask
  task automatic run(input int n, output logic [63:0] rdm);
    logic rd;
    rdm = '0;
    for (int i = 0; i < n; i++) begin
      step(rd);
      rdm[i] = rd;
    end
  endtask
  initial begin
    logic [63:0]  rdm;
    logic         rd;
    logic [767:0] s_rays;
    logic [383:0] s_tri;
    logic [11:0]  s_idx, s_addr;
    logic [3:0]   s_mask;
    int           first;
    b4.in_empty = 1'b1; b4.ray_in = '0; b4.tri_count = '0; b4.out_full = 1'b0;
    b1.in_empty = 1'b1; b1.ray_in = ray_word(99); b1.tri_count = '0; b1.out_full = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 64'(b4.busy), 64'd0);
    chk("rst_mask", 64'(b4.out_mask), 64'd0);
    chk("rst_wr_last", 64'({b4.out_wr_en, b4.out_last, b4.in_rd_en}), 64'd0);
    chk("rst_addr_idx", 64'({b4.mem_addr, b4.out_tri_idx}), 64'd0);
    chk("rst_tri_rays", 64'(|{b4.out_tri, b4.out_rays}), 64'd0);
    reset = 1'b1;
    // full batch of 4 rays, 3 triangles
    first = nid;
    push_rays(4);
    b4.tri_count = 12'd3;
    push_exp(1'b0, 6, 3, 4'hF, first, first + 1, first + 2, first + 3);
    start();
    run(14, rdm);
    chk("t1_pops", rdm, 64'h000F);
    chk("t1_idle", 64'(b4.busy), 64'd0);
    chk("t1_drain", 64'(q4.size()), 64'd0);
    // partial batch of 2 rays
    first = nid;
    push_rays(2);
    b4.tri_count = 12'd2;
    push_exp(1'b0, 5, 2, 4'h3, first, first + 1, 0, 0);
    start();
    run(10, rdm);
    chk("t2_pops", rdm, 64'h0003);
    chk("t2_drain", 64'(q4.size()), 64'd0);
    // zero triangles: rays consumed, nothing written
    push_rays(4);
    b4.tri_count = 12'd0;
    start();
    run(8, rdm);
    chk("t3_pops", rdm, 64'h000F);
    chk("t3_fifo_empty", 64'(fq.size()), 64'd0);
    chk("t3_idle", 64'(b4.busy), 64'd0);
    chk("t3_mask", 64'(b4.out_mask), 64'd0);
    // downstream full across the first EMIT, released after cycle 15
    first = nid;
    push_rays(4);
    b4.tri_count = 12'd2;
    b4.out_full = 1'b1;
    push_exp(1'b0, 16, 2, 4'hF, first, first + 1, first + 2, first + 3);
    start();
    for (int i = 0; i < 16; i++) begin
      step(rd);
      if (i == 6) begin
        s_rays = b4.out_rays; s_tri = b4.out_tri; s_idx = b4.out_tri_idx;
        s_addr = b4.mem_addr; s_mask = b4.out_mask;
        chk("t4_stall_idx", 64'(b4.out_tri_idx), 64'd0);
        chk("t4_stall_tri", 64'(b4.out_tri !== tri_word(0)), 64'd0);
        chk("t4_stall_last", 64'(b4.out_last), 64'd0);
      end
      if (i == 14) begin
        chk("t4_hold_rays", 64'(b4.out_rays !== s_rays), 64'd0);
        chk("t4_hold_tri", 64'(b4.out_tri !== s_tri), 64'd0);
        chk("t4_hold_idx_addr", 64'({b4.out_tri_idx, b4.mem_addr}), 64'({s_idx, s_addr}));
        chk("t4_hold_mask_busy", 64'({b4.out_mask, b4.busy}), 64'({s_mask, 1'b1}));
      end
      if (i == 15) b4.out_full = 1'b0;
    end
    run(6, rdm);
    chk("t4_drain", 64'(q4.size()), 64'd0);
    // reset during EMIT; a fifth ray waits and forms the next batch alone
    first = nid;
    push_rays(5);
    b4.tri_count = 12'd3;
    start();
    run(6, rdm);
    reset = 1'b0;
    #1;
    chk("t5_wr_rd", 64'({b4.out_wr_en, b4.in_rd_en}), 64'd0);
    chk("t5_busy_last", 64'({b4.busy, b4.out_last}), 64'd0);
    chk("t5_mask", 64'(b4.out_mask), 64'd0);
    chk("t5_addr_idx", 64'({b4.mem_addr, b4.out_tri_idx}), 64'd0);
    chk("t5_tri_rays", 64'(|{b4.out_tri, b4.out_rays}), 64'd0);
    run(2, rdm);
    chk("t5_no_pop_in_reset", rdm, 64'd0);
    b4.tri_count = 12'd1;
    reset = 1'b1;
    base = cyc;
    push_exp(1'b0, 4, 1, 4'h1, first + 4, 0, 0, 0);
    run(7, rdm);
    chk("t5_pops", rdm, 64'h0001);
    chk("t5_drain", 64'(q4.size()), 64'd0);
    // single-lane instance, 15 triangles in a 4-bit address space
    b1.tri_count = 4'd15;
    push_exp(1'b1, 3, 15, 4'h1, 99, 0, 0, 0);
    start();
    b1.in_empty = 1'b0;
    run(50, rdm);
    chk("t6_pops", 64'(pops1), 64'd1);
    chk("t6_idle", 64'(b1.busy), 64'd0);
    chk("t6_drain", 64'(q1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ray_batch_streamer.md
# ray_batch_streamer

Parametrised successor to the single-ray streamer. It groups up to LANES rays from the input ray FIFO into one batch. For each batch it walks triangle memory once, addresses 0 to tri_count-1, and issues one instruction per triangle carrying the whole batch to the downstream parallel intersection unit. Each triangle fetch is shared by all LANES rays, which cuts SRAM read bandwidth by up to LANES×. It sits between the input ray FIFO and the hit-test stage, and drives the triangle SRAM read port.

## Interface
Parameters:
- D_BITS, 32, width of one fixed-point scalar.
- M_BITS, 12, triangle memory address width; also the width of the triangle counter.
- LANES, 4, maximum rays per batch (≥1).

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_empty  in  1  ray FIFO empty; ray_in is valid whenever low (first-word-fall-through).
- ray_in  in  6*D_BITS  origin xyz and direction xyz; scalar i at [D_BITS*i +: D_BITS].
- in_rd_en  out  1  pops the FIFO; ray_in is captured in the same cycle.
- tri_count  in  M_BITS  number of triangles in memory; sampled when a batch closes.
- mem_addr  out  M_BITS  SRAM read address; synchronous read, 1-cycle latency.
- mem_data  in  12*D_BITS  triangle data for the address presented in the previous cycle.
- out_full  in  1  downstream full.
- out_wr_en  out  1  instruction write strobe.
- out_rays  out  LANES*6*D_BITS  batch rays; lane j at [6*D_BITS*j +: 6*D_BITS].
- out_mask  out  LANES  lane j holds a valid ray.
- out_tri  out  12*D_BITS  triangle data.
- out_tri_idx  out  M_BITS  triangle address.
- out_last  out  1  high on the final instruction of a batch.
- busy  out  1  state ≠ IDLE.

## Operation
State machine with states IDLE, LOAD, FETCH, WAIT, EMIT.

- **IDLE:**
  - If !in_empty: assert in_rd_en, store ray_in into lane 0, mask←1, lane_cnt←1, go to LOAD.
  - If LANES==1: go directly to batch close.
- **LOAD:**
  - If !in_empty: assert in_rd_en, store ray_in into lane lane_cnt, set that mask bit, increment lane_cnt.
  - The batch closes when lane_cnt reaches LANES after a pop, or when in_empty is high in LOAD (partial batch, no pop that cycle).
  - Unused lanes keep mask=0; their ray contents are don't-care.
- **Batch close:**
  - Sample tri_count.
  - If 0: drop the batch, clear mask, go to IDLE. No instruction is issued.
  - Otherwise: tri_idx←0, go to FETCH.
- **FETCH:** mem_addr=tri_idx; go to WAIT.
- **WAIT:** register mem_data into out_tri and tri_idx into out_tri_idx; go to EMIT.
- **EMIT:**
  - out_wr_en = !out_full (combinational).
  - out_last = (tri_idx == tri_count_s-1).
  - On a write with out_last: go to IDLE and clear mask.
  - On a write without out_last: tri_idx+1, go to FETCH.
  - While out_full is high: hold all outputs stable indefinitely.
- out_rays and out_mask remain stable for the entire batch.
- tri_idx never wraps: the maximum tri_count is 2^M_BITS-1, so the last index is 2^M_BITS-2.
- in_rd_en is never asserted when in_empty is high, and never asserted outside IDLE/LOAD.
- Reset mid-operation:
  - The partial batch is discarded.
  - Popped rays are lost; upstream must re-issue them.
  - No out_wr_en is issued.

## Timing
- Reset values:
  - State IDLE.
  - in_rd_en 0, out_wr_en 0, out_last 0, busy 0.
  - mem_addr 0, out_mask 0, out_tri 0, out_tri_idx 0, out_rays 0.
- Full batch with a continuously non-empty FIFO:
  - Pops occur at cycles 0 to LANES-1.
  - FETCH at cycle LANES, WAIT at LANES+1.
  - First out_wr_en at LANES+2.
- Partial batch of k rays:
  - in_empty is seen at cycle k; FETCH at k+1; first write at k+3.
- Steady state with no backpressure: one instruction every 3 cycles. A batch with N triangles takes 3N cycles after close.
- mem_addr holds its last value outside FETCH.
- After the last write, the earliest next in_rd_en is the following cycle (in IDLE).

## Test plan
- LANES=4, 4 rays preloaded, tri_count=3 -> in_rd_en at cycles 0–3; out_wr_en at cycles 6, 9, 12 with out_tri_idx 0, 1, 2; out_mask=4'b1111; out_last only at cycle 12; out_tri matches SRAM contents.
- 2 rays available, then in_empty -> out_mask=4'b0011; first write at cycle 5; lanes 0–1 equal the input rays.
- tri_count=0 -> rays are popped, out_wr_en is never asserted, and state returns to IDLE.
- out_full held high for 10 cycles during EMIT -> no write occurs; out_* stay stable; the write happens the cycle after out_full falls.
- reset asserted low during EMIT -> all outputs at reset values in the same cycle; no out_wr_en; after release the next batch starts at lane 0.
- LANES=1, M_BITS=4, tri_count=15 -> 15 instructions issued, indices 0–14; out_last on index 14.
